// File: rtl/frog_sprite_pkg.sv
// Shared types and constants for the sprite compositor: object types, table entry
// layout, per-type sprite dimensions and the 8-entry colour palette.
package frog_sprite_pkg;

    typedef enum logic [3:0] {
        NONE       = 4'd0,
        FROG       = 4'd1,
        FIRETRUCK  = 4'd2,
        BUS        = 4'd3,
        MOTORCYCLE = 4'd4,
        SHORTLOG   = 4'd5,
        MEDIUMLOG  = 4'd6,
        LONGLOG    = 4'd7,
        HEART      = 4'd8
    } obj_type_e;

    typedef struct packed {
        obj_type_e   otype;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        flip;
    } obj_entry_t;

    localparam logic [6:0] FROG_W       = 7'd17;
    localparam logic [6:0] FIRETRUCK_W  = 7'd25;
    localparam logic [6:0] BUS_W        = 7'd19;
    localparam logic [6:0] MOTORCYCLE_W = 7'd23;
    localparam logic [6:0] SHORTLOG_W   = 7'd27;
    localparam logic [6:0] MEDIUMLOG_W  = 7'd50;
    localparam logic [6:0] LONGLOG_W    = 7'd73;
    localparam logic [6:0] HEART_W      = 7'd8;

    localparam logic [4:0] FROG_H       = 5'd16;
    localparam logic [4:0] FIRETRUCK_H  = 5'd16;
    localparam logic [4:0] BUS_H        = 5'd14;
    localparam logic [4:0] MOTORCYCLE_H = 5'd16;
    localparam logic [4:0] SHORTLOG_H   = 5'd9;
    localparam logic [4:0] MEDIUMLOG_H  = 5'd9;
    localparam logic [4:0] LONGLOG_H    = 5'd9;
    localparam logic [4:0] HEART_H      = 5'd16;

    // Entry 0 is never selected (transparent); kept so the index maps directly.
    localparam logic [23:0] PALETTE [0:8] = '{
        24'h000000, 24'h000000, 24'h00C000, 24'hE00000, 24'h80C0FF,
        24'hFFE000, 24'hFFFFFF, 24'h808080, 24'h8B4513
    };
    localparam logic [23:0] MAGENTA = 24'hFF00FF;

    function automatic logic [6:0] sprite_w(input obj_type_e t);
        case (t)
            FROG:       return FROG_W;
            FIRETRUCK:  return FIRETRUCK_W;
            BUS:        return BUS_W;
            MOTORCYCLE: return MOTORCYCLE_W;
            SHORTLOG:   return SHORTLOG_W;
            MEDIUMLOG:  return MEDIUMLOG_W;
            LONGLOG:    return LONGLOG_W;
            HEART:      return HEART_W;
            default:    return 7'd0;
        endcase
    endfunction

    function automatic logic [4:0] sprite_h(input obj_type_e t);
        case (t)
            FROG:       return FROG_H;
            FIRETRUCK:  return FIRETRUCK_H;
            BUS:        return BUS_H;
            MOTORCYCLE: return MOTORCYCLE_H;
            SHORTLOG:   return SHORTLOG_H;
            MEDIUMLOG:  return MEDIUMLOG_H;
            LONGLOG:    return LONGLOG_H;
            HEART:      return HEART_H;
            default:    return 5'd0;
        endcase
    endfunction

    function automatic logic [23:0] palette_rgb(input logic [5:0] idx);
        if (idx >= 6'd1 && idx <= 6'd8) begin
            return PALETTE[idx[3:0]];
        end
        return MAGENTA;
    endfunction

endpackage

// File: rtl/sprite_index_lookup.sv
// Combinational font read: selects the bitmap for an object type and returns the
// 6-bit palette index at [row][col]. Type NONE returns the transparent index 0.
module sprite_index_lookup
    import frog_sprite_pkg::*;
(
    input  obj_type_e   i_type,
    input  logic [3:0]  i_row,
    input  logic [6:0]  i_col,
    input  logic [5:0]  i_frog_font       [16][17],
    input  logic [5:0]  i_firetruck_font  [16][25],
    input  logic [5:0]  i_bus_font        [14][19],
    input  logic [5:0]  i_motorcycle_font [16][23],
    input  logic [5:0]  i_shortlog_font   [9][27],
    input  logic [5:0]  i_mediumlog_font  [9][50],
    input  logic [5:0]  i_longlog_font    [9][73],
    input  logic [5:0]  i_heart_font      [16][8],
    output logic [5:0]  o_idx
);

    always_comb begin
        o_idx = 6'd0;
        case (i_type)
            FROG:       o_idx = i_frog_font[i_row][i_col[4:0]];
            FIRETRUCK:  o_idx = i_firetruck_font[i_row][i_col[4:0]];
            BUS:        o_idx = i_bus_font[i_row][i_col[4:0]];
            MOTORCYCLE: o_idx = i_motorcycle_font[i_row][i_col[4:0]];
            SHORTLOG:   o_idx = i_shortlog_font[i_row][i_col[4:0]];
            MEDIUMLOG:  o_idx = i_mediumlog_font[i_row][i_col[5:0]];
            LONGLOG:    o_idx = i_longlog_font[i_row][i_col];
            HEART:      o_idx = i_heart_font[i_row][i_col[2:0]];
            default:    o_idx = 6'd0;
        endcase
    end

endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel sprite compositor with double-buffered object table and 3-stage pipeline.
// Optional macro SPRITE_FLIP_EN enables horizontal mirroring via obj_flip.
module sprite_compositor
    import frog_sprite_pkg::*;
#(
    parameter int NUM_OBJ = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       frame_sync,
    input  logic                       pix_valid,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic [23:0]                bg_rgb,
    input  logic                       obj_we,
    input  logic [$clog2(NUM_OBJ)-1:0] obj_addr,
    input  logic [3:0]                 obj_type,
    input  logic [9:0]                 obj_x,
    input  logic [9:0]                 obj_y,
    input  logic                       obj_flip,
    input  logic [5:0]                 frog_font       [16][17],
    input  logic [5:0]                 firetruck_font  [16][25],
    input  logic [5:0]                 bus_font        [14][19],
    input  logic [5:0]                 motorcycle_font [16][23],
    input  logic [5:0]                 shortlog_font   [9][27],
    input  logic [5:0]                 mediumlog_font  [9][50],
    input  logic [5:0]                 longlog_font    [9][73],
    input  logic [5:0]                 heart_font      [16][8],
    output logic [23:0]                rgb_out,
    output logic                       rgb_valid
);

    obj_entry_t r_shadow [NUM_OBJ];
    obj_entry_t r_active [NUM_OBJ];
    obj_entry_t w_wr_entry;

    // With mirroring disabled the stored flip bit is held at 0, so column = dx.
`ifdef SPRITE_FLIP_EN
    assign w_wr_entry = '{otype: obj_type_e'(obj_type), x: obj_x, y: obj_y, flip: obj_flip};
`else
    logic w_unused_flip;
    assign w_unused_flip = obj_flip;
    assign w_wr_entry = '{otype: obj_type_e'(obj_type), x: obj_x, y: obj_y, flip: 1'b0};
`endif

    // Nonblocking copy means a same-cycle write lands only in the shadow.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (frame_sync) begin
                r_active <= r_shadow;
            end
            if (obj_we) begin
                r_shadow[obj_addr] <= w_wr_entry;
            end
        end
    end

    // ---- S1: hit test against the active table ----
    obj_type_e   w_type_s1 [NUM_OBJ];
    logic [3:0]  w_row_s1  [NUM_OBJ];
    logic [6:0]  w_col_s1  [NUM_OBJ];

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
        logic [6:0]         w_w;
        logic [4:0]         w_h;
        logic signed [10:0] w_dx;
        logic signed [10:0] w_dy;
        logic               w_hit;
        logic [6:0]         w_col;

        assign w_w   = sprite_w(r_active[g].otype);
        assign w_h   = sprite_h(r_active[g].otype);
        assign w_dx  = $signed({1'b0, DrawX}) - $signed({1'b0, r_active[g].x});
        assign w_dy  = $signed({1'b0, DrawY}) - $signed({1'b0, r_active[g].y});
        assign w_hit = (r_active[g].otype != NONE)
                    && !w_dx[10] && (w_dx < $signed({4'b0, w_w}))
                    && !w_dy[10] && (w_dy < $signed({6'b0, w_h}));
        assign w_col = r_active[g].flip ? (w_w - 7'd1 - w_dx[6:0]) : w_dx[6:0];

        // Misses are folded into type NONE so S2 reads a transparent index.
        assign w_type_s1[g] = w_hit ? r_active[g].otype : NONE;
        assign w_row_s1[g]  = w_hit ? w_dy[3:0] : 4'd0;
        assign w_col_s1[g]  = w_hit ? w_col : 7'd0;
    end

    logic        r_vld_p1;
    logic [23:0] r_bg_p1;
    obj_type_e   r_type_p1 [NUM_OBJ];
    logic [3:0]  r_row_p1  [NUM_OBJ];
    logic [6:0]  r_col_p1  [NUM_OBJ];

    // ---- S2: per-entry font lookup ----
    logic [5:0]  w_idx_s2 [NUM_OBJ];

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_lookup
        sprite_index_lookup u_lookup (
            .i_type            (r_type_p1[g]),
            .i_row             (r_row_p1[g]),
            .i_col             (r_col_p1[g]),
            .i_frog_font       (frog_font),
            .i_firetruck_font  (firetruck_font),
            .i_bus_font        (bus_font),
            .i_motorcycle_font (motorcycle_font),
            .i_shortlog_font   (shortlog_font),
            .i_mediumlog_font  (mediumlog_font),
            .i_longlog_font    (longlog_font),
            .i_heart_font      (heart_font),
            .o_idx             (w_idx_s2[g])
        );
    end

    logic        r_vld_p2;
    logic [23:0] r_bg_p2;
    logic [5:0]  r_idx_p2 [NUM_OBJ];

    // ---- S3: priority select and palette lookup ----
    logic        w_found;
    logic [5:0]  w_win_idx;

    always_comb begin
        w_found   = 1'b0;
        w_win_idx = 6'd0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (r_idx_p2[i] != 6'd0) begin
                w_found   = 1'b1;
                w_win_idx = r_idx_p2[i];
            end
        end
    end

    logic        r_vld_p3;
    logic [23:0] r_rgb_p3;

    always_ff @(posedge Clk) begin
        r_bg_p1   <= bg_rgb;
        r_type_p1 <= w_type_s1;
        r_row_p1  <= w_row_s1;
        r_col_p1  <= w_col_s1;
        r_bg_p2   <= r_bg_p1;
        r_idx_p2  <= w_idx_s2;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
            r_rgb_p3 <= 24'h000000;
        end else begin
            r_vld_p1 <= pix_valid;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
            if (!r_vld_p2) begin
                r_rgb_p3 <= 24'h000000;
            end else if (w_found) begin
                r_rgb_p3 <= palette_rgb(w_win_idx);
            end else begin
                r_rgb_p3 <= r_bg_p2;
            end
        end
    end

    assign rgb_out   = r_rgb_p3;
    assign rgb_valid = r_vld_p3;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model of the compositor.
module tb_sprite_compositor;

    localparam logic [3:0] T_NONE = 4'd0, T_FROG = 4'd1, T_BUS = 4'd3;
    localparam logic [3:0] T_LONGLOG = 4'd7, T_HEART = 4'd8;
`ifdef SPRITE_FLIP_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset, frame_sync, pix_valid, obj_we, obj_flip;
    logic [9:0]  DrawX, DrawY, obj_x, obj_y;
    logic [23:0] bg_rgb;
    logic [3:0]  obj_addr, obj_type;
    logic [23:0] rgb_out;
    logic        rgb_valid;

    logic [5:0] f_frog [16][17];
    logic [5:0] f_fire [16][25];
    logic [5:0] f_bus  [14][19];
    logic [5:0] f_moto [16][23];
    logic [5:0] f_slog [9][27];
    logic [5:0] f_mlog [9][50];
    logic [5:0] f_llog [9][73];
    logic [5:0] f_hrt  [16][8];

    int checks = 0;
    int errors = 0;

    // Model tables and expected output pipeline
    int m_sh_t [16], m_sh_x [16], m_sh_y [16], m_sh_f [16];
    int m_ac_t [16], m_ac_x [16], m_ac_y [16], m_ac_f [16];
    logic        pv   [3];
    logic [23:0] prgb [3];

    always #5 Clk = ~Clk;

    sprite_compositor #(.NUM_OBJ(16)) dut (
        .Clk(Clk), .Reset(Reset), .frame_sync(frame_sync), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .bg_rgb(bg_rgb),
        .obj_we(obj_we), .obj_addr(obj_addr), .obj_type(obj_type),
        .obj_x(obj_x), .obj_y(obj_y), .obj_flip(obj_flip),
        .frog_font(f_frog), .firetruck_font(f_fire), .bus_font(f_bus),
        .motorcycle_font(f_moto), .shortlog_font(f_slog), .mediumlog_font(f_mlog),
        .longlog_font(f_llog), .heart_font(f_hrt),
        .rgb_out(rgb_out), .rgb_valid(rgb_valid)
    );

    function automatic int spr_w(input int t);
        case (t)
            1: return 17; 2: return 25; 3: return 19; 4: return 23;
            5: return 27; 6: return 50; 7: return 73; 8: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int spr_h(input int t);
        case (t)
            1: return 16; 2: return 16; 3: return 14; 4: return 16;
            5: return 9;  6: return 9;  7: return 9;  8: return 16;
            default: return 0;
        endcase
    endfunction

    function automatic int mfont(input int t, input int r, input int c);
        case (t)
            1: return int'(f_frog[r][c]);
            2: return int'(f_fire[r][c]);
            3: return int'(f_bus[r][c]);
            4: return int'(f_moto[r][c]);
            5: return int'(f_slog[r][c]);
            6: return int'(f_mlog[r][c]);
            7: return int'(f_llog[r][c]);
            8: return int'(f_hrt[r][c]);
            default: return 0;
        endcase
    endfunction

    function automatic logic [23:0] mpal(input int idx);
        case (idx)
            1: return 24'h000000; 2: return 24'h00C000; 3: return 24'hE00000;
            4: return 24'h80C0FF; 5: return 24'hFFE000; 6: return 24'hFFFFFF;
            7: return 24'h808080; 8: return 24'h8B4513;
            default: return 24'hFF00FF;
        endcase
    endfunction

    function automatic logic [23:0] model_rgb(input int px, input int py, input logic [23:0] bg);
        for (int i = 0; i < 16; i++) begin
            int t, w, h, dx, dy, col, idx;
            t = m_ac_t[i];
            w = spr_w(t);
            h = spr_h(t);
            dx = px - m_ac_x[i];
            dy = py - m_ac_y[i];
            if (t != 0 && dx >= 0 && dx < w && dy >= 0 && dy < h) begin
                col = (FLIP && m_ac_f[i] != 0) ? (w - 1 - dx) : dx;
                idx = mfont(t, dy, col);
                if (idx != 0) return mpal(idx);
            end
        end
        return bg;
    endfunction

    function automatic logic [5:0] rnd_idx();
        if ($urandom_range(0, 9) < 4) return 6'd0;
        return 6'($urandom_range(1, 10));
    endfunction

    // One clock: update the model from the inputs seen at this edge, then compare.
    task automatic tick();
        logic        nv;
        logic [23:0] nrgb;
        nv = 1'b0;
        nrgb = 24'h0;
        if (!Reset && pix_valid) begin
            nv = 1'b1;
            nrgb = model_rgb(int'(DrawX), int'(DrawY), bg_rgb);
        end
        if (Reset) begin
            for (int i = 0; i < 16; i++) begin
                m_sh_t[i] = 0; m_ac_t[i] = 0;
            end
            for (int k = 0; k < 3; k++) begin
                pv[k] = 1'b0; prgb[k] = 24'h0;
            end
        end else begin
            if (frame_sync) begin
                m_ac_t = m_sh_t; m_ac_x = m_sh_x; m_ac_y = m_sh_y; m_ac_f = m_sh_f;
            end
            if (obj_we) begin
                m_sh_t[obj_addr] = int'(obj_type);
                m_sh_x[obj_addr] = int'(obj_x);
                m_sh_y[obj_addr] = int'(obj_y);
                m_sh_f[obj_addr] = int'(obj_flip);
            end
            pv[2] = pv[1]; prgb[2] = prgb[1];
            pv[1] = pv[0]; prgb[1] = prgb[0];
            pv[0] = nv;    prgb[0] = nrgb;
        end
        @(posedge Clk);
        #1;
        checks++;
        assert (rgb_valid === pv[2]) else begin
            errors++;
            $error("FAIL rgb_valid obs=%b exp=%b", rgb_valid, pv[2]);
        end
        checks++;
        assert (rgb_out === prgb[2]) else begin
            errors++;
            $error("FAIL rgb_out obs=%h exp=%h", rgb_out, prgb[2]);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] t, input logic [9:0] x,
                      input logic [9:0] y, input logic f);
        obj_we = 1'b1; obj_addr = a; obj_type = t; obj_x = x; obj_y = y; obj_flip = f;
        tick();
        obj_we = 1'b0;
    endtask

    task automatic fsync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    // Present one pixel (optionally with frame_sync), then check it against a fixed colour.
    task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic [23:0] bg, input logic [23:0] want, input logic fs);
        DrawX = x; DrawY = y; bg_rgb = bg; pix_valid = 1'b1; frame_sync = fs;
        tick();
        pix_valid = 1'b0; frame_sync = 1'b0;
        tick();
        tick();
        checks++;
        assert (rgb_valid === 1'b1 && rgb_out === want) else begin
            errors++;
            $error("FAIL %s obs=%h/%b exp=%h/1", tag, rgb_out, rgb_valid, want);
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) for (int c = 0; c < 17; c++) f_frog[r][c] = rnd_idx();
        for (int r = 0; r < 16; r++) for (int c = 0; c < 25; c++) f_fire[r][c] = rnd_idx();
        for (int r = 0; r < 14; r++) for (int c = 0; c < 19; c++) f_bus[r][c]  = rnd_idx();
        for (int r = 0; r < 16; r++) for (int c = 0; c < 23; c++) f_moto[r][c] = rnd_idx();
        for (int r = 0; r < 9;  r++) for (int c = 0; c < 27; c++) f_slog[r][c] = rnd_idx();
        for (int r = 0; r < 9;  r++) for (int c = 0; c < 50; c++) f_mlog[r][c] = rnd_idx();
        for (int r = 0; r < 9;  r++) for (int c = 0; c < 73; c++) f_llog[r][c] = rnd_idx();
        for (int r = 0; r < 16; r++) for (int c = 0; c < 8;  c++) f_hrt[r][c]  = rnd_idx();
        f_frog[3][7] = 6'd2;  f_frog[0][0] = 6'd0;  f_frog[11][0] = 6'd0;
        f_frog[8][0] = 6'd1;  f_frog[2][13] = 6'd1; f_frog[2][3] = 6'd1;
        f_frog[3][9] = 6'd2;  f_llog[7][10] = 6'd8; f_bus[9][9] = 6'd3;
        f_hrt[11][3] = 6'd1;
        for (int i = 0; i < 16; i++) begin
            m_sh_t[i] = 0; m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_f[i] = 0;
            m_ac_t[i] = 0; m_ac_x[i] = 0; m_ac_y[i] = 0; m_ac_f[i] = 0;
        end
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0; prgb[k] = 24'h0;
        end

        Reset = 1'b1; frame_sync = 1'b0; pix_valid = 1'b0; obj_we = 1'b0; obj_flip = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0; bg_rgb = 24'h0;
        obj_addr = 4'd0; obj_type = 4'd0; obj_x = 10'd0; obj_y = 10'd0;
        tick();
        tick();
        Reset = 1'b0;

        // Empty table: background passes through
        for (int n = 0; n < 80; n++) begin
            pix_valid = (n % 11) != 7;
            DrawX = 10'(n * 8);
            DrawY = 10'(n * 6);
            bg_rgb = 24'h0000FF;
            tick();
        end
        pix_valid = 1'b0;
        probe("bg_only", 10'd5, 10'd5, 24'h0000FF, 24'h0000FF, 1'b0);

        wr(4'd0, T_FROG, 10'd100, 10'd200, 1'b0);
        fsync();
        probe("frog_hit", 10'd107, 10'd203, 24'h123456, 24'h00C000, 1'b0);
        probe("frog_transp", 10'd100, 10'd200, 24'h123456, 24'h123456, 1'b0);
        probe("frog_dx17", 10'd117, 10'd200, 24'h654321, 24'h654321, 1'b0);

        wr(4'd0, T_FROG, 10'd100, 10'd100, 1'b0);
        wr(4'd1, T_LONGLOG, 10'd90, 10'd104, 1'b0);
        fsync();
        probe("log_under", 10'd100, 10'd111, 24'h0000FF, 24'h8B4513, 1'b0);
        probe("frog_over", 10'd100, 10'd108, 24'h0000FF, 24'h000000, 1'b0);

        wr(4'd0, T_BUS, 10'd630, 10'd470, 1'b0);
        probe("bus_pending", 10'd639, 10'd479, 24'h0000FF, 24'h0000FF, 1'b0);
        fsync();
        probe("bus_hit", 10'd639, 10'd479, 24'h0000FF, 24'hE00000, 1'b0);
        probe("bus_nowrap", 10'd0, 10'd0, 24'h0000FF, 24'h0000FF, 1'b0);
        probe("bus_dx19", 10'd649, 10'd470, 24'h00FF00, 24'h00FF00, 1'b0);

        wr(4'd0, T_FROG, 10'd0, 10'd0, 1'b1);
        wr(4'd1, T_NONE, 10'd0, 10'd0, 1'b0);
        fsync();
        probe("flip_3_2", 10'd3, 10'd2, 24'h0000FF, 24'h000000, 1'b0);
        probe("flip_7_3", 10'd7, 10'd3, 24'h0000FF, 24'h00C000, 1'b0);

        wr(4'd0, T_NONE, 10'd0, 10'd0, 1'b0);
        fsync();
        obj_we = 1'b1; obj_addr = 4'd0; obj_type = T_HEART; obj_x = 10'd0; obj_y = 10'd0;
        obj_flip = 1'b0; frame_sync = 1'b1;
        tick();
        obj_we = 1'b0; frame_sync = 1'b0;
        probe("heart_old", 10'd3, 10'd11, 24'h0000FF, 24'h0000FF, 1'b1);
        probe("heart_new", 10'd3, 10'd11, 24'h0000FF, 24'h000000, 1'b0);

        // Reset wins over a concurrent write and commit
        obj_we = 1'b1; obj_addr = 4'd1; obj_type = T_FROG; obj_x = 10'd0; obj_y = 10'd0;
        frame_sync = 1'b1; Reset = 1'b1; pix_valid = 1'b1;
        tick();
        obj_we = 1'b0; frame_sync = 1'b0; Reset = 1'b0; pix_valid = 1'b0;
        probe("rst_active", 10'd3, 10'd2, 24'hABCDEF, 24'hABCDEF, 1'b0);
        fsync();
        probe("rst_shadow", 10'd3, 10'd2, 24'hABCDEF, 24'hABCDEF, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            pix_valid = ($urandom_range(0, 7) != 0);
            DrawX = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(1000, 1023))
                                                 : 10'($urandom_range(0, 100));
            DrawY = 10'($urandom_range(0, 40));
            bg_rgb = 24'($urandom());
            obj_we = ($urandom_range(0, 3) == 0);
            obj_addr = 4'($urandom_range(0, 15));
            obj_type = 4'($urandom_range(0, 8));
            obj_x = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023))
                                                : 10'($urandom_range(0, 80));
            obj_y = 10'($urandom_range(0, 30));
            obj_flip = 1'($urandom_range(0, 1));
            frame_sync = ($urandom_range(0, 24) == 0);
            Reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        Reset = 1'b0; pix_valid = 1'b0; obj_we = 1'b0; frame_sync = 1'b0;
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
